// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_scoreboard: per-register RAW/WAW scoreboard driving pipeline stalls |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hazard_scoreboard #(
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int LAT_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter bit STORE_FWD       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ifidValid,
  input  logic [RF_ADDR_WIDTH-1:0]      ifidRs1,
  input  logic [RF_ADDR_WIDTH-1:0]      ifidRs2,
  input  logic [RF_ADDR_WIDTH-1:0]      ifidRd,
  input  logic                          ifidUsesRs1,
  input  logic                          ifidUsesRs2,
  input  logic                          ifidRegWrite,
  input  logic                          ifidMemWrite,
  input  logic [LAT_WIDTH-1:0]          ifidLat,
  input  logic                          ifidVarLat,
  input  logic                          wbValid,
  input  logic [RF_ADDR_WIDTH-1:0]      wbRd,
  input  logic                          branchOrJump,
  output logic                          stall_n,
  output logic                          flushIdEx,
  output logic                          flushIfIdExMem,
  output logic [2**RF_ADDR_WIDTH-1:0]   busyVec,
  output logic                          sbError
);

  localparam int                   NREG    = 2 ** RF_ADDR_WIDTH;
  localparam int                   OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]     MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0]     OUT_ONE = OUT_W'(1);
  localparam logic [LAT_WIDTH-1:0] LAT_ONE = LAT_WIDTH'(1);

  logic [NREG-1:0][LAT_WIDTH-1:0] w_cnt;
  logic [NREG-1:0]                w_pend;
  logic [OUT_W-1:0]               r_out_cnt;
  logic                           r_sb_error;

  logic w_wb_rs1, w_wb_rs2, w_wb_rd;
  logic w_haz_rs1, w_haz_rs2_raw, w_store_fwd, w_haz_rs2, w_haz_waw, w_haz_full;
  logic w_stall, w_issue, w_issue_fix, w_issue_var;
  logic w_complete, w_stray, w_ovf, w_unf;

  // A completion in this cycle is visible to ID through the writeback bypass.
  assign w_wb_rs1 = wbValid && (wbRd == ifidRs1);
  assign w_wb_rs2 = wbValid && (wbRd == ifidRs2);
  assign w_wb_rd  = wbValid && (wbRd == ifidRd);

  assign w_haz_rs1 = ifidUsesRs1 && (ifidRs1 != '0) &&
                     ((w_cnt[ifidRs1] != '0) || (w_pend[ifidRs1] && !w_wb_rs1));

  assign w_haz_rs2_raw = ifidUsesRs2 && (ifidRs2 != '0) &&
                         ((w_cnt[ifidRs2] != '0) || (w_pend[ifidRs2] && !w_wb_rs2));

  // Store data is needed only in MEM, so a producer one cycle out is forwarded there.
  assign w_store_fwd = STORE_FWD && ifidMemWrite &&
                       (w_cnt[ifidRs2] == LAT_ONE) && !w_pend[ifidRs2];

  assign w_haz_rs2 = w_haz_rs2_raw && !w_store_fwd;

  assign w_haz_waw = ifidRegWrite && (ifidRd != '0) && w_pend[ifidRd] && !w_wb_rd;

  assign w_haz_full = ifidVarLat && ifidRegWrite && (r_out_cnt == MAX_OUT) && !wbValid;

  assign w_stall = ifidValid && (w_haz_rs1 || w_haz_rs2 || w_haz_waw || w_haz_full);

  always_comb begin
    stall_n        = 1'b1;
    flushIdEx      = 1'b0;
    flushIfIdExMem = 1'b0;
    if (branchOrJump) begin
      stall_n        = 1'b1;
      flushIdEx      = 1'b1;
      flushIfIdExMem = 1'b1;
    end else if (w_stall) begin
      stall_n   = 1'b0;
      flushIdEx = 1'b1;
    end
  end

  assign w_issue     = ifidValid && !w_stall && !branchOrJump && ifidRegWrite && (ifidRd != '0);
  assign w_issue_fix = w_issue && !ifidVarLat;
  assign w_issue_var = w_issue && ifidVarLat;

  assign w_complete = wbValid && (wbRd != '0) &&  w_pend[wbRd];
  assign w_stray    = wbValid && (wbRd != '0) && !w_pend[wbRd];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        assign w_cnt[gi]  = '0;
        assign w_pend[gi] = 1'b0;
      end else begin : g_trk
        logic [LAT_WIDTH-1:0] r_cnt;
        logic                 r_pend;
        logic                 w_sel_rd;
        logic                 w_sel_wb;

        assign w_sel_rd = (ifidRd == RF_ADDR_WIDTH'(gi));
        assign w_sel_wb = (wbRd   == RF_ADDR_WIDTH'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
          end else begin
            if (w_issue_fix && w_sel_rd) begin
              r_cnt <= ifidLat;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - LAT_ONE;
            end
            // A re-issue to the register completing this cycle keeps it pending.
            if (w_issue_var && w_sel_rd) begin
              r_pend <= 1'b1;
            end else if (w_complete && w_sel_wb) begin
              r_pend <= 1'b0;
            end
          end
        end

        assign w_cnt[gi]  = r_cnt;
        assign w_pend[gi] = r_pend;
      end
    end

    for (genvar gb = 0; gb < NREG; gb++) begin : g_busy
      assign busyVec[gb] = (w_cnt[gb] != '0) || w_pend[gb];
    end
  endgenerate

  assign w_ovf = w_issue_var && !w_complete && (r_out_cnt == MAX_OUT);
  assign w_unf = w_complete && !w_issue_var && (r_out_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt  <= '0;
      r_sb_error <= 1'b0;
    end else begin
      if (w_issue_var && !w_complete && !w_ovf) begin
        r_out_cnt <= r_out_cnt + OUT_ONE;
      end else if (w_complete && !w_issue_var && !w_unf) begin
        r_out_cnt <= r_out_cnt - OUT_ONE;
      end
      r_sb_error <= r_sb_error || w_stray || w_ovf || w_unf;
    end
  end

  assign sbError = r_sb_error;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// Bench for hazard_scoreboard: directed vector table, corner sequences, and
// random stimulus against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int MAXO = 4;
  localparam bit SFWD = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ifidValid, ifidUsesRs1, ifidUsesRs2, ifidRegWrite, ifidMemWrite;
  logic          ifidVarLat, wbValid, branchOrJump;
  logic [AW-1:0] ifidRs1, ifidRs2, ifidRd, wbRd;
  logic [1:0]    ifidLat;
  logic          stall_n, flushIdEx, flushIfIdExMem, sbError;
  logic [NR-1:0] busyVec;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .RF_ADDR_WIDTH(AW), .LAT_WIDTH(2), .MAX_OUTSTANDING(MAXO), .STORE_FWD(SFWD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ifidValid(ifidValid), .ifidRs1(ifidRs1), .ifidRs2(ifidRs2), .ifidRd(ifidRd),
    .ifidUsesRs1(ifidUsesRs1), .ifidUsesRs2(ifidUsesRs2),
    .ifidRegWrite(ifidRegWrite), .ifidMemWrite(ifidMemWrite),
    .ifidLat(ifidLat), .ifidVarLat(ifidVarLat),
    .wbValid(wbValid), .wbRd(wbRd), .branchOrJump(branchOrJump),
    .stall_n(stall_n), .flushIdEx(flushIdEx), .flushIfIdExMem(flushIfIdExMem),
    .busyVec(busyVec), .sbError(sbError)
  );

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, mw;
    logic [1:0] lat;
    logic       vl, wbv;
    logic [4:0] wbrd;
    logic       br;
    logic [2:0] ctl;
    logic [31:0] busy;
  } vec_t;

  vec_t tbl[$];
  int tests = 0;
  int fails = 0;

  int   m_cnt [NR];
  bit   m_pend[NR];
  int   m_out;
  bit   m_err;
  bit   m_stall;
  logic [2:0]  e_ctl;
  logic [31:0] e_busy;

  function automatic vec_t mk(input logic valid, input int rs1, input int rs2, input int rd,
                              input logic u1, input logic u2, input logic rw, input logic mw,
                              input int lat, input logic vl, input logic wbv, input int wbrd,
                              input logic br, input logic [2:0] ctl, input logic [31:0] busy);
    vec_t v;
    v.valid = valid; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.u1 = u1; v.u2 = u2; v.rw = rw; v.mw = mw; v.lat = 2'(lat); v.vl = vl;
    v.wbv = wbv; v.wbrd = 5'(wbrd); v.br = br; v.ctl = ctl; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_cnt[r]  = 0;
      m_pend[r] = 1'b0;
    end
    m_out = 0;
    m_err = 1'b0;
  endtask

  function automatic bit m_haz(input logic use_it, input logic [4:0] r);
    bool_busy: begin end
    return use_it && (r != 0) &&
           (m_cnt[r] > 0 || (m_pend[r] && !(wbValid && wbRd == r)));
  endfunction

  task automatic model_eval();
    bit h2;
    h2 = m_haz(ifidUsesRs2, ifidRs2);
    if (SFWD && ifidMemWrite && m_cnt[ifidRs2] == 1 && !m_pend[ifidRs2]) h2 = 1'b0;
    m_stall = ifidValid && (m_haz(ifidUsesRs1, ifidRs1) || h2 ||
              (ifidRegWrite && ifidRd != 0 && m_pend[ifidRd] && !(wbValid && wbRd == ifidRd)) ||
              (ifidVarLat && ifidRegWrite && m_out == MAXO && !wbValid));
    e_ctl = branchOrJump ? 3'b111 : (m_stall ? 3'b010 : 3'b100);
    for (int r = 0; r < NR; r++) e_busy[r] = (m_cnt[r] > 0) || m_pend[r];
  endtask

  task automatic model_tick();
    bit issue, done;
    int nxt;
    issue = ifidValid && !branchOrJump && !m_stall && ifidRegWrite && ifidRd != 0;
    for (int r = 0; r < NR; r++) if (m_cnt[r] > 0) m_cnt[r]--;
    if (issue && !ifidVarLat) m_cnt[ifidRd] = int'(ifidLat);
    done = wbValid && wbRd != 0 && m_pend[wbRd];
    if (wbValid && wbRd != 0 && !m_pend[wbRd]) m_err = 1'b1;
    if (done) m_pend[wbRd] = 1'b0;
    if (issue && ifidVarLat) m_pend[ifidRd] = 1'b1;
    nxt = m_out + ((issue && ifidVarLat) ? 1 : 0) - (done ? 1 : 0);
    if (nxt > MAXO) begin m_err = 1'b1; nxt = MAXO; end
    if (nxt < 0)    begin m_err = 1'b1; nxt = 0;    end
    m_out = nxt;
  endtask

  task automatic drive(input vec_t v);
    ifidValid = v.valid; ifidRs1 = v.rs1; ifidRs2 = v.rs2; ifidRd = v.rd;
    ifidUsesRs1 = v.u1; ifidUsesRs2 = v.u2; ifidRegWrite = v.rw; ifidMemWrite = v.mw;
    ifidLat = v.lat; ifidVarLat = v.vl; wbValid = v.wbv; wbRd = v.wbrd;
    branchOrJump = v.br;
  endtask

  // Called at posedge+1; returns at posedge+4 with the model evaluated.
  task automatic step(input vec_t v);
    drive(v);
    #3;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  function automatic logic [31:0] ctl_now();
    return {29'd0, stall_n, flushIdEx, flushIfIdExMem};
  endfunction

  initial begin
    vec_t idle, v;
    int   plist[$];
    idle = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 3'b100, 0);
    drive(idle);
    model_reset();

    tbl.push_back(mk(1,1,0,5, 1,0,1,0, 1,0,0,0, 0, 3'b010 ^ 3'b110, 32'h0));
    tbl.push_back(mk(1,5,0,6, 1,0,1,0, 0,0,0,0, 0, 3'b010, 32'h20));
    tbl.push_back(mk(1,5,0,6, 1,0,1,0, 0,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,1,0,5, 1,0,1,0, 1,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,2,5,0, 1,1,0,1, 0,0,0,0, 0, 3'b100, 32'h20));
    tbl.push_back(mk(1,1,0,5, 1,0,1,0, 1,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,5,2,0, 1,1,0,1, 0,0,0,0, 0, 3'b010, 32'h20));
    tbl.push_back(mk(1,5,2,0, 1,1,0,1, 0,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,3,4,7, 1,1,1,0, 0,1,0,0, 0, 3'b100, 32'h0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(1,7,0,8, 1,0,1,0, 0,0,0,0, 0, 3'b010, 32'h80));
    tbl.push_back(mk(1,7,0,8, 1,0,1,0, 0,0,1,7, 0, 3'b100, 32'h80));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,0,0,10, 0,0,1,0, 0,1,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,0,0,11, 0,0,1,0, 0,1,0,0, 0, 3'b100, 32'h400));
    tbl.push_back(mk(1,0,0,12, 0,0,1,0, 0,1,0,0, 0, 3'b100, 32'hC00));
    tbl.push_back(mk(1,0,0,13, 0,0,1,0, 0,1,0,0, 0, 3'b100, 32'h1C00));
    tbl.push_back(mk(1,0,0,14, 0,0,1,0, 0,1,0,0, 0, 3'b010, 32'h3C00));
    tbl.push_back(mk(1,0,0,14, 0,0,1,0, 0,1,1,10, 0, 3'b100, 32'h3C00));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 3'b100, 32'h7800));
    tbl.push_back(mk(1,0,0,15, 0,0,1,0, 0,1,0,0, 0, 3'b010, 32'h7800));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,11, 0, 3'b100, 32'h7800));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,12, 0, 3'b100, 32'h7000));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,13, 0, 3'b100, 32'h6000));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1,14, 0, 3'b100, 32'h4000));
    tbl.push_back(mk(1,1,0,5, 1,0,1,0, 2,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,5,0,6, 1,0,1,0, 3,0,0,0, 1, 3'b111, 32'h20));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 3'b100, 32'h20));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,0,0,0, 0,0,1,0, 3,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,0,0,1, 1,1,1,0, 0,0,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,0,0,0, 0,0,1,0, 0,1,0,0, 0, 3'b100, 32'h0));
    tbl.push_back(mk(1,0,0,0, 1,1,0,0, 0,0,0,0, 0, 3'b100, 32'h0));

    // Reset state
    #12;
    check("reset ctl", ctl_now(), 32'h4);
    check("reset busy", busyVec, 32'h0);
    check("reset err", {31'd0, sbError}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i]);
      check($sformatf("tbl%0d ctl", i), ctl_now(), {29'd0, tbl[i].ctl});
      check($sformatf("tbl%0d busy", i), busyVec, tbl[i].busy);
      check($sformatf("tbl%0d err", i), {31'd0, sbError}, 32'h0);
      tick();
    end

    // Stray completion on x9 sets the sticky error
    step(mk(0,0,0,0, 0,0,0,0, 0,0,1,9, 0, 3'b100, 32'h0));
    check("stray pre err", {31'd0, sbError}, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      step(idle);
      check($sformatf("stray sticky%0d", k), {31'd0, sbError}, 32'h1);
      tick();
    end

    // Asynchronous reset while a consumer is stalled
    step(mk(1,1,0,5, 1,0,1,0, 3,0,0,0, 0, 3'b100, 32'h0));
    tick();
    step(mk(1,5,0,6, 1,0,1,0, 0,0,0,0, 0, 3'b010, 32'h20));
    check("midstall ctl", ctl_now(), 32'h2);
    rst_n = 1'b0;
    #1;
    check("async rst ctl", ctl_now(), 32'h4);
    check("async rst busy", busyVec, 32'h0);
    check("async rst err", {31'd0, sbError}, 32'h0);
    model_reset();
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand rst busy", busyVec, 32'h0);
        model_reset();
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
      end
      v = idle;
      v.valid = ($urandom_range(0, 9) != 0);
      v.rs1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 7));
      v.rd    = 5'($urandom_range(0, 7));
      v.u1    = 1'($urandom);
      v.u2    = 1'($urandom);
      v.rw    = ($urandom_range(0, 9) < 7);
      v.mw    = !v.rw && 1'($urandom);
      v.lat   = 2'($urandom_range(0, 3));
      v.vl    = ($urandom_range(0, 3) == 0);
      v.br    = ($urandom_range(0, 11) == 0);
      plist.delete();
      for (int r = 1; r < NR; r++) if (m_pend[r]) plist.push_back(r);
      if ($urandom_range(0, 2) == 0) begin
        if (plist.size() > 0 && $urandom_range(0, 49) != 0) begin
          v.wbv  = 1'b1;
          v.wbrd = 5'(plist[$urandom_range(0, plist.size() - 1)]);
        end else if ($urandom_range(0, 9) == 0) begin
          v.wbv  = 1'b1;
          v.wbrd = 5'($urandom_range(0, 31));
        end
      end
      step(v);
      check($sformatf("rand%0d ctl", c), ctl_now(), {29'd0, e_ctl});
      check($sformatf("rand%0d busy", c), busyVec, e_busy);
      check($sformatf("rand%0d err", c), {31'd0, sbError}, {31'd0, m_err});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational load-use hazard detector of the RV32I pipeline.
- Tracks pending register writes from fixed-latency producers (loads, multi-cycle ALU ops) with per-register countdown counters.
- Tracks pending writes from variable-latency producers (divider, non-blocking loads) with a pending bit plus a completion tag.
- Drives the same stall/flush controls to the PC, IF/ID, ID/EX and EX/MEM stage registers.

Parameters:
- RF_ADDR_WIDTH, 5, register-file address width; 2**RF_ADDR_WIDTH entries tracked, x0 never tracked.
- LAT_WIDTH, 2, width of the fixed-latency field; maximum latency is 2**LAT_WIDTH-1.
- MAX_OUTSTANDING, 4, maximum in-flight variable-latency ops (≥1).
- STORE_FWD, 1, when 1 a store's rs2 does not stall when its producer has 1 cycle remaining, because MEM-stage forwarding covers it.

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- ifidValid in 1: ID holds a real instruction, not a bubble.
- ifidRs1 in RF_ADDR_WIDTH: source 1 of the ID instruction.
- ifidRs2 in RF_ADDR_WIDTH: source 2 of the ID instruction.
- ifidRd in RF_ADDR_WIDTH: destination of the ID instruction.
- ifidUsesRs1 in 1: ID instruction reads rs1.
- ifidUsesRs2 in 1: ID instruction reads rs2.
- ifidRegWrite in 1: ID instruction writes rd.
- ifidMemWrite in 1: ID instruction is a store.
- ifidLat in LAT_WIDTH: result latency of the ID instruction; 0 = fully forwarded, not tracked.
- ifidVarLat in 1: ID instruction has variable latency; ifidLat is ignored.
- wbValid in 1: a variable-latency result completes this cycle.
- wbRd in RF_ADDR_WIDTH: destination of the completing result.
- branchOrJump in 1: a taken branch or jump resolved in EX.
- stall_n out 1: low freezes PC and IF/ID.
- flushIdEx out 1: inserts a bubble into ID/EX.
- flushIfIdExMem out 1: flushes IF/ID and EX/MEM.
- busyVec out 2**RF_ADDR_WIDTH: bit r set when r has a nonzero counter or a pending bit.
- sbError out 1: sticky protocol error flag.

Behaviour:
- Reset: all counters 0, all pending bits 0, outstanding count 0, sbError 0. Combinational outputs at reset are stall_n=1, flushIdEx=0, flushIfIdExMem=0, busyVec=0.
- State per register r≠0: cnt[r] (LAT_WIDTH bits) and pend[r] (1 bit). Global state: outCnt, range 0..MAX_OUTSTANDING.
- hazRs1 = ifidUsesRs1 && rs1≠0 && (cnt[rs1]≠0 || (pend[rs1] && !(wbValid && wbRd==rs1))).
- hazRs2: same form as hazRs1, on rs2. Additionally masked when STORE_FWD && ifidMemWrite && cnt[rs2]==1 && !pend[rs2].
- hazWaw = ifidRegWrite && rd≠0 && pend[rd] && !(wbValid && wbRd==rd).
- hazFull = ifidVarLat && ifidRegWrite && outCnt==MAX_OUTSTANDING && !wbValid.
- stall = ifidValid && (hazRs1 || hazRs2 || hazWaw || hazFull).
- Outputs, first match wins:
  - branchOrJump → {stall_n, flushIdEx, flushIfIdExMem} = 111.
  - else stall → 010.
  - else 100.
- Issue = ifidValid && stall_n && !branchOrJump && ifidRegWrite && ifidRd≠0.
- Sequential update, every rising edge:
  - Every nonzero cnt decrements by 1.
  - Issue, fixed latency: cnt[rd] ← ifidLat. The load overrides the decrement of the same register.
  - Issue, variable latency: pend[rd] ← 1.
  - wbValid && pend[wbRd]: pend[wbRd] ← 0.
  - Simultaneous variable issue and completion on the same rd: issue wins, pend stays 1.
  - outCnt += variable issue − valid completion; both in one cycle leaves it unchanged.
- Timing: a load with ifidLat=1 issued at the end of cycle t stalls a dependent consumer during t+1 only, and the consumer leaves ID at the end of t+2.
- Completion same-cycle bypass: a consumer waiting on rd does not stall in the cycle where wbValid && wbRd==rd.
- Branch in the same cycle as a hazard: no issue occurs; counters and completions still advance.
- sbError sets on wbValid with rd≠0 and pend[wbRd]==0, or when outCnt would overflow or underflow. On error, outCnt saturates and does not wrap. sbError clears only on reset.
- Asynchronous reset mid-operation drops all tracking immediately.

Test Plan:
- Load x5 with ifidLat=1, next instruction add reading x5 → stall_n=0 and flushIdEx=1 for exactly 1 cycle, then 100; busyVec[5]=1 for 1 cycle.
- Same as above but the consumer is a store with rs2=x5 and STORE_FWD=1 → no stall. Store with rs1=x5 → 1-cycle stall.
- Div to x7 (variable), consumer reads x7, wbValid with wbRd=7 asserted 6 cycles later → stall during those 6 cycles before wbValid. Released in the wbValid cycle by the bypass. pend[7] is cleared.
- Issue 4 variable ops with MAX_OUTSTANDING=4; a fifth variable op stalls until a wbValid arrives, and issues in that same cycle. outCnt stays 4.
- Hazard pending and branchOrJump asserted in the same cycle → output 111, no cnt load. A stray wbValid on x9 with nothing pending → sbError=1 until rst_n low.
- Operand x0 with rd=0 producers → never stalls, busyVec[0]=0. Assert rst_n low mid-stall → outputs 100 and busyVec=0 asynchronously.
